mem_sram_ctrl: RTL
==================

# mem_sram_ctrl

- Memory-stage consumer of the EXE/MEM pipeline register outputs (mem_r_en, mem_w_en, alu_result, val_rm).
- Performs one 32-bit data-memory access per instruction against an external 16-bit asynchronous SRAM, as two half-word accesses with programmable wait states.
- Asserts stall to freeze the upstream pipeline until the access completes.
- Presents read data to the MEM/WB register.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- WAIT_CYCLES, 2: cycles each half-word access is held; must be ≥1.
- SRAM_AW, 18: SRAM half-word address width.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- alu_result  in  32  byte address.
- val_rm  in  32  store data.
- ready  out  1  access completes this cycle.
- stall  out  1  freeze PC and all pipeline registers.
- read_data  out  32  load result, held until the next load completes.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to the SRAM bus.
- sram_dq_in  in  16  read data from the SRAM bus.
- sram_dq_oe  out  1  drive enable for sram_dq_out.
- sram_we_n  out  1  SRAM write strobe, active-low.

## Operation
- req = mem_r_en | mem_w_en.
- Write has priority if both are high; this case is illegal from the decoder, but the behaviour is defined.
- Word address: wa = (alu_result − BASE_ADDR) >> 2, computed mod 2^32 and truncated to SRAM_AW−1 bits. No range check; wrap is silent.
- Half-word addresses: low = {wa,1'b0}, high = {wa,1'b1}. Little-endian: bits [15:0] go to low, [31:16] to high.
- FSM states: IDLE, LO, HI, DONE. A counter cnt (≥ clog2(WAIT_CYCLES) bits) tracks wait cycles.
- IDLE:
  - If req: latch op (write if mem_w_en), clear cnt, go to LO.
  - Otherwise stay in IDLE.
- LO: sram_addr = low.
  - Write: sram_dq_out = val_rm[15:0], sram_dq_oe = 1, sram_we_n = 0.
  - Increment cnt each cycle. When cnt == WAIT_CYCLES−1, clear cnt and go to HI.
  - Read: capture sram_dq_in into read_data[15:0] on that final cycle.
- HI: same as LO, using address high and data bits [31:16]. Go to DONE.
- DONE: ready = 1, sram_we_n = 1, sram_dq_oe = 0. Go to IDLE unconditionally.
- ready = (state == DONE). stall = req & ~ready, combinational.
- Inputs are held stable by the frozen pipeline while stall = 1. The controller latches only op; address and data are read live.
- sram_we_n is high in IDLE and DONE, so each store produces two write pulses separated by the address change.
- read_data changes only on the capture cycles of a load; stores leave it unchanged.
- Reset values: state IDLE, cnt 0, read_data 0, ready 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0. stall follows req combinationally.

## Timing
- Load or store sampled in IDLE at cycle 0:
  - LO occupies cycles 1..W, HI occupies cycles W+1..2W, DONE is cycle 2W+1.
  - stall is high for cycles 0..2W; ready is high in cycle 2W+1.
  - Default W = 2: ready in cycle 5, five stall cycles.
- The pipeline advances on the clock edge ending DONE. A new request appears in the following IDLE cycle; there is no back-to-back merge and one IDLE cycle occurs between accesses.
- req dropping mid-access is illegal. The controller still completes the access; ready pulses and stall reads 0.
- rst during LO or HI aborts the access: next cycle IDLE, sram_we_n = 1, no further SRAM writes, read_data = 0. A half-completed store leaves the SRAM partially written; this is accepted.
- Read data is sampled at the end of the last wait cycle of each half, giving W cycles of SRAM access time.

## Structure
- Shared package/defines file mem_defs: FSM state encoding (IDLE = 0, LO = 1, HI = 2, DONE = 3) and default BASE_ADDR.
- Single module, no sub-module. The wait counter is inline.
- Top-level instantiates mem_sram_ctrl between the EXE/MEM and MEM/WB registers. Its stall is ORed into the hazard-unit freeze.
- Top-level muxes MEM/WB data: read_data when mem_r_en, else alu_result.

## Test plan
- Reset then idle, no requests: ready = 0, stall = 0, sram_we_n = 1, sram_dq_oe = 0, read_data = 0 for 10 cycles.
- Store with alu_result = 1028, val_rm = 0xDEADBEEF, W = 2:
  - Cycles 1–2: addr = 2, dq_out = 0xBEEF, we_n = 0.
  - Cycles 3–4: addr = 3, dq_out = 0xDEAD, we_n = 0.
  - ready in cycle 5; stall in cycles 0–4.
- Load at 1028, with an SRAM model returning 0xBEEF and 0xDEAD: read_data = 0xDEADBEEF in cycle 5; ready in cycle 5.
- Load at 1024 followed immediately by a store at 1032: one IDLE cycle between accesses, second ready at cycle 11. read_data is unchanged by the store.
- W = 1, store then load at alu_result = 1020 (wrap): both accesses use addr 0x3FFFE/0x3FFFF; ready in cycle 3.
- rst asserted in cycle 2 of a store: cycle 3 shows IDLE, we_n = 1, dq_oe = 0, ready = 0. Mem_r_en and mem_w_en high together: executes as a store.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM state
// encoding, default parameter values and a counter-width helper.
package mem_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;

    // A single wait cycle still needs a one-bit counter to stay well formed.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// External 16-bit asynchronous SRAM bus. The controller is the master;
// the SRAM device (or its model) is the slave.
interface mem_sram_ctrl_if
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_AW = DEFAULT_SRAM_AW
) ();

    logic [SRAM_AW-1:0] addr;
    logic [15:0]        dq_out;
    logic [15:0]        dq_in;
    logic               dq_oe;
    logic               we_n;

    modport master (
        output addr,
        output dq_out,
        output dq_oe,
        output we_n,
        input  dq_in
    );

    modport slave (
        input  addr,
        input  dq_out,
        input  dq_oe,
        input  we_n,
        output dq_in
    );

endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: turns one 32-bit load/store from the EXE/MEM
// register into two half-word accesses on a 16-bit asynchronous SRAM,
// holding each half for WAIT_CYCLES cycles and stalling the pipeline
// until the access finishes.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR),
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_r_en,
    input  logic            mem_w_en,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     val_rm,
    output logic            ready,
    output logic            stall,
    output logic [31:0]     read_data,
    mem_sram_ctrl_if.master sram
);

    localparam int unsigned     CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op_write;
    logic               req;
    logic               last;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_addr;
    logic               unused_offset_bits;

    // Address and data are taken live from the frozen pipeline register;
    // only the operation type is remembered across the access.
    assign req       = mem_r_en | mem_w_en;
    assign last      = (cnt == CNT_LAST);
    assign offset    = alu_result - BASE_ADDR;
    assign word_addr = offset[SRAM_AW:2];

    // Out-of-window address bits wrap silently; they are intentionally dropped.
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign ready = (state == DONE);
    assign stall = req & ~ready;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each half stays up for WAIT_CYCLES cycles, DONE lasts one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)  state_next = LO;
            LO:      if (last) state_next = HI;
            HI:      if (last) state_next = DONE;
            DONE:              state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    // Wait counter, latched operation and read-data capture at the end of each half.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_write  <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_write <= mem_w_en;
                    end
                end
                LO, HI: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (!op_write && last) begin
                        if (state == LO) begin
                            read_data[15:0] <= sram.dq_in;
                        end else begin
                            read_data[31:16] <= sram.dq_in;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // SRAM bus drive: address and write strobe are only active in the two halves.
    always_comb begin
        sram.addr   = '0;
        sram.dq_out = '0;
        sram.dq_oe  = 1'b0;
        sram.we_n   = 1'b1;
        case (state)
            LO: begin
                sram.addr = {word_addr, 1'b0};
                if (op_write) begin
                    sram.dq_out = val_rm[15:0];
                    sram.dq_oe  = 1'b1;
                    sram.we_n   = 1'b0;
                end
            end
            HI: begin
                sram.addr = {word_addr, 1'b1};
                if (op_write) begin
                    sram.dq_out = val_rm[31:16];
                    sram.dq_oe  = 1'b1;
                    sram.we_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
